pwm_fade_sequencer: RTL
=======================

Name: pwm_fade_sequencer

Overview:
Sequences duty-cycle updates into the 4-channel PWM controller. The host loads a target duty and a step size per channel. The block then ramps each channel's duty toward its target, one step per update tick. A round-robin scheduler shares the controller's single 32-bit command word among the four channels. It sits between the host register interface and the PWM controller's command input.

Parameters:
DUTY_W, 20, duty field width; equals command[19:0] width.
UPDATE_DIV, 1000, clock cycles between scheduler ticks; legal range >= 3.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  host write strobe, one cycle
wr_ch  in  2  channel index for the write
wr_target  in  DUTY_W  target duty for the write
wr_step  in  DUTY_W  ramp step for the write; 0 = jump directly to target
command  out  32  PWM command word; [31:30] channel, [29:20] zero, [19:0] duty
cmd_strobe  out  1  one-cycle pulse when command changes
at_target  out  4  per channel, 1 when current duty == target duty
busy  out  1  OR of ~at_target

Behaviour:
- Reset (synchronous, high): every cur, tgt and step register = 0; command = 0; cmd_strobe = 0; at_target = 4'hF; busy = 0; divider = 0; FSM = S_WAIT; last_ch = 3, so channel 0 is served first. Reset mid-ramp abandons the ramp and no strobe follows.
- Divider: free-running 0..UPDATE_DIV-1. tick = 1 when divider == UPDATE_DIV-1.
- Host write: wr_en loads tgt[wr_ch] and step[wr_ch] at the clock edge. cur is not touched. Writes are always accepted.
- FSM S_WAIT: on tick, go to S_PICK. Otherwise stay.
- FSM S_PICK: search channels in order last_ch+1, +2, +3, +4 (mod 4). Select the first channel with cur != tgt.
  - If none is found, go to S_WAIT.
  - Otherwise compute d = tgt - cur as a signed DUTY_W+1 value.
  - If step == 0 or |d| <= step: cur <= tgt. Otherwise cur <= cur ± step, toward tgt.
  - Latch sel_ch, then go to S_ISSUE.
- FSM S_ISSUE: command <= {sel_ch, 10'b0, new cur}; cmd_strobe = 1 for this cycle only; last_ch <= sel_ch; go to S_WAIT.
- Latency: tick cycle to the cmd_strobe cycle is 2 clocks. While work is pending, strobes are exactly UPDATE_DIV cycles apart.
- Only one channel advances per tick. The duty never overshoots the target, and the arithmetic never wraps.
- command holds its value between strobes. The PWM controller samples it as a level.
- Collision: a write to the channel S_PICK selects in that same cycle does not affect that pick, which uses the pre-write tgt/step. The new target applies from the next tick.
- at_target and busy are combinational from the cur/tgt registers.

Decomposition:
- Package pwm_fade_pkg holds:
  - CH_W = 2, NUM_CH = 4;
  - the FSM state enum {S_WAIT, S_PICK, S_ISSUE};
  - command field positions CMD_CH_HI = 31, CMD_CH_LO = 30, CMD_DUTY_HI = 19.
- One sub-module, pwm_rr_picker: a combinational round-robin first-pending finder. Inputs are the 4-bit pending mask and last_ch; outputs are found and sel_ch.
- Step arithmetic stays inline in the top level.

Test Plan:
All scenarios use UPDATE_DIV = 4.
1. Reset held 2 cycles, then released -> command = 0x00000000, cmd_strobe = 0, at_target = 4'hF, busy = 0. No strobe over 20 cycles.
2. Write ch1, target 0x80000, step 0x40000 -> strobes with command 0x40040000, then 0x40080000, 4 cycles apart. busy then falls. No third strobe.
3. Write ch2, target 0xC0000, step 0 -> exactly one strobe, command 0x800C0000. at_target[2] = 1.
4. Ramp down: ch1 at 0x80000, write target 0x10000, step 0x30000 -> strobes 0x40050000, 0x40020000, 0x40010000 (clamped). No underflow.
5. ch0 and ch3 both pending, target 0x00300, step 0x00100 -> strobe channel order 0, 3, 0, 3, 0, 3. Final commands are 0x00000300 and 0xC0000300.
6. Ramp in progress on ch1; assert reset for 1 cycle between strobes -> the next cycle shows command = 0 and busy = 0. No strobe for 3×UPDATE_DIV cycles.

Source files
------------

// File: rtl/pwm_fade_pkg.sv
// Shared constants and types for the PWM fade sequencer.
// Channel count, command word layout and scheduler states.
package pwm_fade_pkg;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;

  localparam int CMD_CH_HI   = 31;
  localparam int CMD_CH_LO   = 30;
  localparam int CMD_DUTY_HI = 19;

  typedef enum logic [1:0] {
    S_WAIT  = 2'd0,
    S_PICK  = 2'd1,
    S_ISSUE = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/pwm_rr_picker.sv
// Round-robin first-pending finder.
// Searches last_ch+1 .. last_ch+4 (mod NUM_CH).
module pwm_rr_picker
  import pwm_fade_pkg::*;
(
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   last_ch,
  output logic              found,
  output logic [CH_W-1:0]   sel_ch
);

  logic [CH_W-1:0] idx;

  always_comb begin
    found  = 1'b0;
    sel_ch = last_ch;
    idx    = last_ch;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = last_ch + CH_W'(k);
      if (!found && pending[idx]) begin
        found  = 1'b1;
        sel_ch = idx;
      end
    end
  end

endmodule

// File: rtl/pwm_fade_sequencer.sv
// Ramps four PWM duty values toward host targets, one step per tick,
// sharing a single command word through a round-robin scheduler.
module pwm_fade_sequencer
  import pwm_fade_pkg::*;
#(
  parameter int DUTY_W     = 20,
  parameter int UPDATE_DIV = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DUTY_W-1:0] wr_target,
  input  logic [DUTY_W-1:0] wr_step,
  output logic [31:0]       command,
  output logic              cmd_strobe,
  output logic [NUM_CH-1:0] at_target,
  output logic              busy
);

  localparam int DIV_W = $clog2(UPDATE_DIV);

  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  fsm_state_e        state;

  logic [DUTY_W-1:0] cur  [NUM_CH];
  logic [DUTY_W-1:0] tgt  [NUM_CH];
  logic [DUTY_W-1:0] step [NUM_CH];

  logic [CH_W-1:0]   last_ch;
  logic [CH_W-1:0]   sel_ch;
  logic [NUM_CH-1:0] pending;
  logic              found;
  logic [CH_W-1:0]   pick_ch;

  logic [DUTY_W-1:0]        p_cur;
  logic [DUTY_W-1:0]        p_tgt;
  logic [DUTY_W-1:0]        p_step;
  logic [DUTY_W-1:0]        nxt_cur;
  logic signed [DUTY_W:0]   diff;
  logic [DUTY_W:0]          mag;
  logic [31:0]              cmd_nxt;

  assign tick = (div_cnt == DIV_W'(UPDATE_DIV - 1));

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      pending[i] = (cur[i] != tgt[i]);
    end
  end

  assign at_target = ~pending;
  assign busy      = |pending;

  pwm_rr_picker u_picker (
    .pending (pending),
    .last_ch (last_ch),
    .found   (found),
    .sel_ch  (pick_ch)
  );

  // Signed distance one bit wider than duty so nothing wraps.
  always_comb begin
    p_cur  = cur[pick_ch];
    p_tgt  = tgt[pick_ch];
    p_step = step[pick_ch];
    diff   = $signed({1'b0, p_tgt}) - $signed({1'b0, p_cur});
    mag    = diff[DUTY_W] ? $unsigned(-diff) : $unsigned(diff);
    if (p_step == '0 || mag <= {1'b0, p_step}) begin
      nxt_cur = p_tgt;
    end else if (diff[DUTY_W]) begin
      nxt_cur = p_cur - p_step;
    end else begin
      nxt_cur = p_cur + p_step;
    end
  end

  always_comb begin
    cmd_nxt = '0;
    cmd_nxt[CMD_CH_HI:CMD_CH_LO] = pick_ch;
    cmd_nxt[CMD_DUTY_HI:0]       = nxt_cur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt    <= '0;
      state      <= S_WAIT;
      last_ch    <= CH_W'(NUM_CH - 1);
      sel_ch     <= '0;
      command    <= '0;
      cmd_strobe <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cur[i]  <= '0;
        tgt[i]  <= '0;
        step[i] <= '0;
      end
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      cmd_strobe <= 1'b0;
      if (wr_en) begin
        tgt[wr_ch]  <= wr_target;
        step[wr_ch] <= wr_step;
      end
      // Command and strobe are both valid during the S_ISSUE cycle.
      unique case (state)
        S_WAIT: begin
          if (tick) state <= S_PICK;
        end
        S_PICK: begin
          if (!found) begin
            state <= S_WAIT;
          end else begin
            cur[pick_ch] <= nxt_cur;
            sel_ch       <= pick_ch;
            command      <= cmd_nxt;
            cmd_strobe   <= 1'b1;
            state        <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          last_ch <= sel_ch;
          state   <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

endmodule
